universal_shift_register: RTL and testbench

//  Parametrised N-bit universal shift register: hold, logical shift left/right,

---
 rtl/usr_pkg.sv | 20 ++
 rtl/usr_shift_core.sv | 30 +++
 rtl/universal_shift_register.sv | 133 +++++++++++++
 tb/tb_universal_shift_register.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared mode codes and FSM state encoding for the universal shift register.
package usr_pkg;

   localparam int unsigned MODE_W = 3;

   localparam logic [MODE_W-1:0] USR_HOLD  = 3'd0;
   localparam logic [MODE_W-1:0] USR_SHL   = 3'd1;
   localparam logic [MODE_W-1:0] USR_SHR   = 3'd2;
   localparam logic [MODE_W-1:0] USR_ROTL  = 3'd3;
   localparam logic [MODE_W-1:0] USR_ROTR  = 3'd4;
   localparam logic [MODE_W-1:0] USR_ASR   = 3'd5;
   localparam logic [MODE_W-1:0] USR_LOAD  = 3'd6;
   localparam logic [MODE_W-1:0] USR_CLEAR = 3'd7;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } usr_state_e;

endpackage

// File: rtl/usr_shift_core.sv
// Combinational next-value function of the universal shift register.
module usr_shift_core
   import usr_pkg::*;
#(
   parameter int unsigned N = 8
) (
   input  logic [N-1:0]      cur_i,
   input  logic [MODE_W-1:0] mode_i,
   input  logic              ser_in_lsb_i,
   input  logic              ser_in_msb_i,
   input  logic [N-1:0]      par_in_i,
   output logic [N-1:0]      nxt_c_o
);

   always_comb begin
      nxt_c_o = cur_i;
      case (mode_i)
         USR_HOLD:  nxt_c_o = cur_i;
         USR_SHL:   nxt_c_o = {cur_i[N-2:0], ser_in_lsb_i};
         USR_SHR:   nxt_c_o = {ser_in_msb_i, cur_i[N-1:1]};
         USR_ROTL:  nxt_c_o = {cur_i[N-2:0], cur_i[N-1]};
         USR_ROTR:  nxt_c_o = {cur_i[0], cur_i[N-1:1]};
         USR_ASR:   nxt_c_o = {cur_i[N-1], cur_i[N-1:1]};
         USR_LOAD:  nxt_c_o = par_in_i;
         USR_CLEAR: nxt_c_o = '0;
         default:   nxt_c_o = cur_i;
      endcase
   end

endmodule

// File: rtl/universal_shift_register.sv
// N-bit universal shift register with single-step and counted burst operation.
// Optional registered parity output enabled by defining USR_PARITY_EN.
module universal_shift_register
   import usr_pkg::*;
#(
   parameter int unsigned N     = 8,
   parameter int unsigned CNT_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic [MODE_W-1:0] mode,
   input  logic              start,
   input  logic [CNT_W-1:0]  burst_len,
   input  logic              ser_in_lsb,
   input  logic              ser_in_msb,
   input  logic [N-1:0]      par_in,
   output logic [N-1:0]      out,
   output logic              ser_out_msb,
   output logic              ser_out_lsb,
   output logic              busy,
   output logic              done
`ifdef USR_PARITY_EN
   ,
   output logic              parity
`endif
);

   usr_state_e        state_q, state_d;
   logic [CNT_W-1:0]  remaining_q, remaining_d;
   logic [MODE_W-1:0] mode_q, mode_d;
   logic [N-1:0]      out_q, out_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [MODE_W-1:0] op_mode;
   logic [N-1:0]      nxt;
   logic              last_op;

   // A burst replays the mode latched at start; single steps use the live mode.
   assign op_mode = (state_q == ST_RUN) ? mode_q : mode;
   assign last_op = (remaining_q == CNT_W'(1));

   usr_shift_core #(.N(N)) u_core (
      .cur_i        (out_q),
      .mode_i       (op_mode),
      .ser_in_lsb_i (ser_in_lsb),
      .ser_in_msb_i (ser_in_msb),
      .par_in_i     (par_in),
      .nxt_c_o      (nxt)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         remaining_q <= '0;
         mode_q      <= USR_HOLD;
         out_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         mode_q      <= mode_d;
         out_q       <= out_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // Next-state and burst counter.
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      mode_d      = mode_q;
      case (state_q)
         ST_IDLE: begin
            if (start && (burst_len != '0)) begin
               state_d     = ST_RUN;
               remaining_d = burst_len;
               mode_d      = mode;
            end
         end
         ST_RUN: begin
            remaining_d = remaining_q - CNT_W'(1);
            if (last_op) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Register data and handshake outputs; start wins over en in IDLE.
   always_comb begin
      out_d  = out_q;
      busy_d = 1'b0;
      done_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               busy_d = (burst_len != '0);
               done_d = (burst_len == '0);
            end else if (en) begin
               out_d = nxt;
            end
         end
         ST_RUN: begin
            out_d  = nxt;
            busy_d = !last_op;
            done_d = last_op;
         end
         default: ;
      endcase
   end

   assign out         = out_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign ser_out_msb = out_q[N-1];
   assign ser_out_lsb = out_q[0];

`ifdef USR_PARITY_EN
   logic parity_q;

   // Parity tracks the value being written so it lands with out.
   always_ff @(posedge clk) begin
      if (reset) parity_q <= 1'b0;
      else       parity_q <= ^out_d;
   end

   assign parity = parity_q;
`endif

endmodule

// File: tb/tb_universal_shift_register.sv
// Randomised scoreboard bench for universal_shift_register (N=8, CNT_W=4).
module tb_universal_shift_register;

   typedef struct {
      logic [7:0] out;
      logic       busy;
      logic       done;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset, en, start, ser_in_lsb, ser_in_msb;
   logic [2:0] mode;
   logic [3:0] burst_len;
   logic [7:0] par_in;
   logic [7:0] out;
   logic       ser_out_msb, ser_out_lsb, busy, done;
`ifdef USR_PARITY_EN
   logic       parity;
`endif

   int   checks = 0;
   int   errors = 0;
   exp_t sb_q[$];

   // Reference model: plain integer arithmetic on the register value.
   int   m_val  = 0;
   int   m_left = 0;
   int   m_mode = 0;

   always #5 clk = ~clk;

   universal_shift_register #(.N(8), .CNT_W(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .en          (en),
      .mode        (mode),
      .start       (start),
      .burst_len   (burst_len),
      .ser_in_lsb  (ser_in_lsb),
      .ser_in_msb  (ser_in_msb),
      .par_in      (par_in),
      .out         (out),
      .ser_out_msb (ser_out_msb),
      .ser_out_lsb (ser_out_lsb),
      .busy        (busy),
      .done        (done)
`ifdef USR_PARITY_EN
      ,
      .parity      (parity)
`endif
   );

   function automatic int apply_op(int v, int m, int lsb, int msb, int p);
      case (m)
         0: return v;
         1: return ((v * 2) + lsb) % 256;
         2: return (v / 2) + msb * 128;
         3: return ((v * 2) % 256) + (v / 128);
         4: return (v / 2) + (v % 2) * 128;
         5: return (v / 2) + (v / 128) * 128;
         6: return p;
         default: return 0;
      endcase
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, advance the model, queue the post-edge expectation.
   task automatic drv(input logic r, input logic e, input logic [2:0] m, input logic st,
                      input logic [3:0] bl, input logic lsb, input logic msb, input logic [7:0] p);
      exp_t x;
      reset = r; en = e; mode = m; start = st; burst_len = bl;
      ser_in_lsb = lsb; ser_in_msb = msb; par_in = p;
      x.busy = 1'b0;
      x.done = 1'b0;
      if (r) begin
         m_val = 0; m_left = 0;
      end else if (m_left > 0) begin
         m_val  = apply_op(m_val, m_mode, int'(lsb), int'(msb), int'(p));
         m_left = m_left - 1;
         x.busy = (m_left > 0);
         x.done = (m_left == 0);
      end else if (st) begin
         if (bl != 4'd0) begin
            m_left = int'(bl); m_mode = int'(m); x.busy = 1'b1;
         end else begin
            x.done = 1'b1;
         end
      end else if (e) begin
         m_val = apply_op(m_val, int'(m), int'(lsb), int'(msb), int'(p));
      end
      x.out = 8'(m_val);
      sb_q.push_back(x);
      @(posedge clk);
      #2;
   endtask

   // Monitor: compare every registered output just after each edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("out", out, e.out);
            chk("busy", {7'd0, busy}, {7'd0, e.busy});
            chk("done", {7'd0, done}, {7'd0, e.done});
            chk("ser_out_msb", {7'd0, ser_out_msb}, {7'd0, e.out[7]});
            chk("ser_out_lsb", {7'd0, ser_out_lsb}, {7'd0, e.out[0]});
`ifdef USR_PARITY_EN
            chk("parity", {7'd0, parity}, {7'd0, ^e.out});
`endif
         end
      end
   end

   initial begin
      drv(1, 0, 0, 0, 0, 0, 0, 8'h00);
      drv(1, 0, 0, 0, 0, 0, 0, 8'h00);
      // Single-step operations from known values
      drv(0, 1, 3'd6, 0, 0, 0, 0, 8'hA5);
      drv(0, 1, 3'd1, 0, 0, 1, 0, 8'h00);
      drv(0, 1, 3'd6, 0, 0, 0, 0, 8'hA5);
      drv(0, 1, 3'd2, 0, 0, 0, 0, 8'h00);
      drv(0, 1, 3'd6, 0, 0, 0, 0, 8'h80);
      drv(0, 1, 3'd5, 0, 0, 0, 0, 8'h00);
      drv(0, 0, 3'd7, 0, 0, 0, 0, 8'h00);
      // ROTL burst of 3 from 81 while en/start/mode are toggled
      drv(0, 1, 3'd6, 0, 0, 0, 0, 8'h81);
      drv(0, 1, 3'd3, 1, 4'd3, 0, 0, 8'h00);
      drv(0, 1, 3'd7, 1, 4'd9, 1, 1, 8'hFF);
      drv(0, 1, 3'd6, 1, 4'd1, 1, 1, 8'hFF);
      drv(0, 1, 3'd7, 0, 4'd0, 1, 1, 8'hFF);
      drv(0, 0, 3'd0, 0, 0, 0, 0, 8'h00);
      // Zero-length burst, start has priority over en
      drv(0, 1, 3'd7, 1, 4'd0, 0, 0, 8'h00);
      drv(0, 0, 3'd0, 0, 0, 0, 0, 8'h00);
      // SHR burst of 5 from FF, aborted by reset in its second RUN cycle
      drv(0, 1, 3'd6, 0, 0, 0, 0, 8'hFF);
      drv(0, 0, 3'd2, 1, 4'd5, 0, 0, 8'h00);
      drv(0, 0, 3'd0, 0, 0, 0, 0, 8'h00);
      drv(1, 0, 3'd0, 0, 0, 0, 0, 8'h00);
      drv(0, 0, 3'd0, 0, 0, 0, 0, 8'h00);
      drv(0, 0, 3'd0, 0, 0, 0, 0, 8'h00);
      // Long ROTR burst wrapping past N, then a LOAD burst reloading each cycle
      drv(0, 1, 3'd6, 0, 0, 0, 0, 8'h3C);
      drv(0, 0, 3'd4, 1, 4'd15, 0, 0, 8'h00);
      for (int i = 0; i < 16; i++) drv(0, 0, 3'd0, 0, 0, 1'($urandom), 1'($urandom), 8'($urandom));
      drv(0, 0, 3'd6, 1, 4'd4, 0, 0, 8'h00);
      for (int i = 0; i < 5; i++) drv(0, 0, 3'd0, 0, 0, 0, 0, 8'($urandom));
      // Randomised traffic
      for (int i = 0; i < 800; i++) begin
         logic       r, st;
         logic [3:0] bl;
         r  = ($urandom_range(0, 59) == 0);
         st = ($urandom_range(0, 5) == 0);
         bl = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
         drv(r, 1'($urandom), 3'($urandom), st, bl, 1'($urandom), 1'($urandom), 8'($urandom));
      end
      for (int i = 0; i < 18; i++) drv(0, 0, 3'd0, 0, 0, 0, 0, 8'h00);
      @(posedge clk);
      #3;
      chk("scoreboard_drained", 8'(sb_q.size()), 8'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
